debounce_sync: RTL and testbench

//   Front-end conditioning stage that sits directly upstream of the D flip-flop.

---
 rtl/debounce_sync.sv | 127 ++++++++++++
 tb/tb_debounce_sync.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Synchroniser plus saturating stability filter for a raw asynchronous level.
// Optional rise/fall strobes are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_sync #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter bit          RESET_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic busy,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

   localparam logic [0:0] STABLE = 1'b0;
   localparam logic [0:0] CHECK  = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s_out;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             q_nxt;
   logic             busy_nxt;

   // Synchroniser chain; only the last stage is allowed into the filter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
      end
   end

   assign s_out = sync[SYNC_STAGES-1];

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= STABLE;
         cnt   <= CNT_ZERO;
         q     <= RESET_VAL;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         q     <= q_nxt;
         busy  <= busy_nxt;
      end
   end

   // Qualification: any return of s_out to q throws away the accumulated count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      q_nxt     = q;
      case (state)
         STABLE: begin
            cnt_nxt = CNT_ZERO;
            if (s_out != q) begin
               if (STABLE_CYCLES == 1) begin
                  q_nxt = s_out;
               end else begin
                  state_nxt = CHECK;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         CHECK: begin
            if (s_out == q) begin
               state_nxt = STABLE;
               cnt_nxt   = CNT_ZERO;
            end else if (cnt == CNT_LAST) begin
               q_nxt     = s_out;
               state_nxt = STABLE;
               cnt_nxt   = CNT_ZERO;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = STABLE;
            cnt_nxt   = CNT_ZERO;
         end
      endcase
      busy_nxt = (state_nxt == CHECK);
   end

`ifdef DEBOUNCE_EDGE_EN
   logic rise_r;
   logic fall_r;

   // Strobes share the edge that updates q, so they line up with the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         rise_r <= q_nxt & ~q;
         fall_r <= ~q_nxt & q;
      end
   end

   assign rise = rise_r;
   assign fall = fall_r;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

   // Structural invariants of the filter.
   a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_MAX);
   a_busy_state: assert property (@(posedge clk) disable iff (!rst_n) busy == (state == CHECK));
   a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n) !(rise && fall));

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync at default parameters; strobe expectations
// follow whether DEBOUNCE_EDGE_EN is defined for the build.
module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic d;
   logic q;
   logic busy;
   logic rise;
   logic fall;

   int unsigned n_cmp;
   int unsigned n_err;

   debounce_sync dut (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (d),
      .q    (q),
      .busy (busy),
      .rise (rise),
      .fall (fall)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      d     = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         n_cmp += 4;
         if (q !== 1'b0)    begin n_err++; $display("FAIL reset c=%0d q got %b exp 0", c, q); end
         if (busy !== 1'b0) begin n_err++; $display("FAIL reset c=%0d busy got %b exp 0", c, busy); end
         if (rise !== 1'b0) begin n_err++; $display("FAIL reset c=%0d rise got %b exp 0", c, rise); end
         if (fall !== 1'b0) begin n_err++; $display("FAIL reset c=%0d fall got %b exp 0", c, fall); end
         tick();
      end
      d     = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp += 2;
         if (q !== 1'b0)    begin n_err++; $display("FAIL reset_idle c=%0d q got %b exp 0", c, q); end
         if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle c=%0d busy got %b exp 0", c, busy); end
      end
   endtask

   task automatic test_clean_step();
      logic eq, eb, er;
      d = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         eq = (e >= 6);
         eb = (e >= 3 && e <= 5);
         er = EDGE_EN && (e == 6);
         n_cmp += 4;
         if (q !== eq)      begin n_err++; $display("FAIL step e=%0d q got %b exp %b", e, q, eq); end
         if (busy !== eb)   begin n_err++; $display("FAIL step e=%0d busy got %b exp %b", e, busy, eb); end
         if (rise !== er)   begin n_err++; $display("FAIL step e=%0d rise got %b exp %b", e, rise, er); end
         if (fall !== 1'b0) begin n_err++; $display("FAIL step e=%0d fall got %b exp 0", e, fall); end
      end
   endtask

   task automatic test_release();
      logic eq, eb, ef;
      d = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         eq = (e < 6);
         eb = (e >= 3 && e <= 5);
         ef = EDGE_EN && (e == 6);
         n_cmp += 4;
         if (q !== eq)      begin n_err++; $display("FAIL release e=%0d q got %b exp %b", e, q, eq); end
         if (busy !== eb)   begin n_err++; $display("FAIL release e=%0d busy got %b exp %b", e, busy, eb); end
         if (fall !== ef)   begin n_err++; $display("FAIL release e=%0d fall got %b exp %b", e, fall, ef); end
         if (rise !== 1'b0) begin n_err++; $display("FAIL release e=%0d rise got %b exp 0", e, rise); end
      end
   endtask

   // Three cycles high reaches cnt=3 at most, then the low level cancels it.
   task automatic test_glitch();
      logic eb;
      d = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         if (e == 4) d = 1'b0;
         tick();
         eb = (e >= 3 && e <= 5);
         n_cmp += 3;
         if (q !== 1'b0)    begin n_err++; $display("FAIL glitch e=%0d q got %b exp 0", e, q); end
         if (busy !== eb)   begin n_err++; $display("FAIL glitch e=%0d busy got %b exp %b", e, busy, eb); end
         if (rise !== 1'b0) begin n_err++; $display("FAIL glitch e=%0d rise got %b exp 0", e, rise); end
      end
   endtask

   task automatic test_bounce();
      logic eq, eb, er;
      for (int k = 0; k < 10; k++) begin
         d = (k % 2 == 0);
         tick();
         n_cmp += 2;
         if (q !== 1'b0)    begin n_err++; $display("FAIL bounce k=%0d q got %b exp 0", k, q); end
         if (rise !== 1'b0) begin n_err++; $display("FAIL bounce k=%0d rise got %b exp 0", k, rise); end
      end
      d = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         eq = (e >= 6);
         eb = (e == 1) || (e >= 3 && e <= 5);
         er = EDGE_EN && (e == 6);
         n_cmp += 4;
         if (q !== eq)      begin n_err++; $display("FAIL bounce_hold e=%0d q got %b exp %b", e, q, eq); end
         if (busy !== eb)   begin n_err++; $display("FAIL bounce_hold e=%0d busy got %b exp %b", e, busy, eb); end
         if (rise !== er)   begin n_err++; $display("FAIL bounce_hold e=%0d rise got %b exp %b", e, rise, er); end
         if (fall !== 1'b0) begin n_err++; $display("FAIL bounce_hold e=%0d fall got %b exp 0", e, fall); end
      end
   endtask

   task automatic test_reset_mid_check();
      logic eq, eb, er;
      d = 1'b1;
      for (int e = 1; e <= 3; e++) tick();
      n_cmp += 1;
      if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre busy got %b exp 1", busy); end
      rst_n = 1'b0;
      #1;
      n_cmp += 2;
      if (q !== 1'b0)    begin n_err++; $display("FAIL midrst_async q got %b exp 0", q); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_async busy got %b exp 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         eq = (e >= 6);
         eb = (e >= 3 && e <= 5);
         er = EDGE_EN && (e == 6);
         n_cmp += 3;
         if (q !== eq)    begin n_err++; $display("FAIL midrst e=%0d q got %b exp %b", e, q, eq); end
         if (busy !== eb) begin n_err++; $display("FAIL midrst e=%0d busy got %b exp %b", e, busy, eb); end
         if (rise !== er) begin n_err++; $display("FAIL midrst e=%0d rise got %b exp %b", e, rise, er); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_clean_step();
      test_release();
      test_glitch();
      test_bounce();
      test_release();
      test_reset_mid_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
